// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-requester cache-line memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam int LINE_WORDS_DEFAULT = 8;
    localparam int ADDR_W_DEFAULT     = 32;

    function automatic logic [1:0] owner_onehot(input owner_t owner);
        return (owner == OWN_D) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of cache-side and memory-side signals around the arbiter.
interface mem_arbiter_if #(
    parameter int LINE_WORDS = mem_arbiter_pkg::LINE_WORDS_DEFAULT,
    parameter int ADDR_W     = mem_arbiter_pkg::ADDR_W_DEFAULT
);
    localparam int BEAT_W = $clog2(LINE_WORDS);

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic [1:0]        gnt;
    logic [BEAT_W-1:0] beat;
    logic [31:0]       rdata;
    logic              rvalid;
    logic              i_done;
    logic              d_done;
    logic              busy;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    // master is the arbiter itself; slave is the caches plus main memory.
    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        output gnt, beat, rdata, rvalid, i_done, d_done, busy,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        input  gnt, beat, rdata, rvalid, i_done, d_done, busy,
               mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker: combinational choice plus the last-grant register.
module mem_arb_rr
    import mem_arbiter_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   i_req,
    input  logic   d_req,
    input  logic   update,
    input  owner_t done_owner,
    output owner_t pick,
    output logic   pick_valid
);

    owner_t last;

    // NOTE: reset is synchronous, so it lives inside the clocked block; state uses <= only.
    always_ff @(posedge clk) begin
        if (rst) begin
            last <= OWN_D;
        end else if (update) begin
            last <= done_owner;
        end
    end

    always_comb begin
        pick_valid = i_req | d_req;
        pick       = OWN_I;
        if (i_req && d_req) begin
            pick = (last == OWN_D) ? OWN_I : OWN_D;
        end else if (d_req) begin
            pick = OWN_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates ICache refills and DCache refills/write-backs onto one word-wide
// memory port, moving one full cache line per grant.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEFAULT,
    parameter int ADDR_W     = ADDR_W_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus
);

    localparam int                BEAT_W    = $clog2(LINE_WORDS);
    localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'(LINE_WORDS * 4 - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    state_t            state;
    owner_t            owner;
    logic [ADDR_W-1:0] base;
    logic              we;
    logic [BEAT_W-1:0] beat;
    logic [1:0]        gnt;
    logic              busy;
    logic              mem_req;
    logic              i_done;
    logic              d_done;

    owner_t            pick;
    logic              pick_valid;

    mem_arb_rr u_rr (
        .clk        (clk),
        .rst        (rst),
        .i_req      (bus.i_req),
        .d_req      (bus.d_req),
        .update     (state == DONE),
        .done_owner (owner),
        .pick       (pick),
        .pick_valid (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            owner   <= OWN_I;
            base    <= '0;
            we      <= 1'b0;
            beat    <= '0;
            gnt     <= 2'b00;
            busy    <= 1'b0;
            mem_req <= 1'b0;
            i_done  <= 1'b0;
            d_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state   <= BURST;
                        owner   <= pick;
                        base    <= ((pick == OWN_D) ? bus.d_addr : bus.i_addr) & ~OFF_MASK;
                        we      <= (pick == OWN_D) && bus.d_we;
                        beat    <= '0;
                        gnt     <= owner_onehot(pick);
                        busy    <= 1'b1;
                        mem_req <= 1'b1;
                    end
                end
                BURST: begin
                    if (bus.mem_ack) begin
                        if (beat == LAST_BEAT) begin
                            state   <= DONE;
                            beat    <= '0;
                            gnt     <= 2'b00;
                            mem_req <= 1'b0;
                            i_done  <= (owner == OWN_I);
                            d_done  <= (owner == OWN_D);
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    i_done <= 1'b0;
                    d_done <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The base has its offset bits cleared, so OR-ing the beat in is a concatenation.
    logic in_burst;
    assign in_burst      = (state == BURST);
    assign bus.gnt       = gnt;
    assign bus.beat      = beat;
    assign bus.busy      = busy;
    assign bus.mem_req   = mem_req;
    assign bus.i_done    = i_done;
    assign bus.d_done    = d_done;
    assign bus.mem_we    = in_burst && we;
    assign bus.mem_addr  = in_burst ? (base | ADDR_W'({beat, 2'b00})) : '0;
    assign bus.mem_wdata = (in_burst && we) ? bus.d_wdata : 32'h0;
    assign bus.rvalid    = bus.mem_ack && in_burst && !we;
    assign bus.rdata     = bus.rvalid ? bus.mem_rdata : 32'h0;

endmodule
